wb_line_memory_slave: RTL and testbench

//  Wishbone slave (responder) that terminates the 128-bit line bus driven by the L2/evict-buffer path.

---
 rtl/wb_line_memory_slave_pkg.sv | 11 +
 rtl/wb_line_memory_slave_array.sv | 25 ++
 rtl/wb_line_memory_slave.sv | 147 ++++++++++++++
 tb/tb_wb_line_memory_slave.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_line_memory_slave_pkg.sv
// Shared line-bus types: 128-bit line, 16-lane byte select, responder FSM states.
package lc3b_types;

  localparam int LINE_BYTES = 16;

  typedef logic [127:0]          lc3b_line;
  typedef logic [LINE_BYTES-1:0] lc3b_line_sel;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} wb_mem_state_t;

endpackage

// File: rtl/wb_line_memory_slave_array.sv
// Single-port line RAM: one byte-wide bank per lane, combinational read, synchronous masked write.
module wb_line_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  lc3b_line_sel         be,
  input  lc3b_line             wdata,
  output lc3b_line             rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  for (genvar l = 0; l < LINE_BYTES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
      if (be[l]) mem[addr] <= wdata[8*l +: 8];

    assign rdata[8*l +: 8] = mem[addr];
  end

endmodule

// File: rtl/wb_line_memory_slave.sv
// Wishbone line-memory responder: programmable read/write latency, byte-masked writes,
// periodic refresh blackout answered with RTY, saturating traffic counters.
module wb_line_memory_slave
  import lc3b_types::*;
#(
  parameter int ADDR_BITS      = 12,
  parameter int READ_LAT       = 4,
  parameter int WRITE_LAT      = 3,
  parameter int REFRESH_PERIOD = 1024,
  parameter int REFRESH_LEN    = 8,
  parameter int CNT_W          = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CYC,
  input  logic                 STB,
  input  logic                 WE,
  input  logic [ADDR_BITS-1:0] ADR,
  input  logic [15:0]          SEL,
  input  logic [127:0]         DAT_M,
  output logic [127:0]         DAT_S,
  output logic                 ACK,
  output logic                 RTY,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  input  logic                 rd_clear,
  input  logic                 wr_clear
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  wb_mem_state_t        state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 rty_q, rty_d;
  logic                 req, accept, load_rd, blackout;
  logic                 we_q;
  logic [ADDR_BITS-1:0] adr_q;
  lc3b_line_sel         sel_q, be;
  lc3b_line             dat_q, rd_line;
  logic [CNT_W-1:0]     rd_cnt_q, wr_cnt_q;

  assign req = CYC & STB;

  if (REFRESH_PERIOD > 0) begin : g_refresh
    localparam int TMR_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge CLK) begin
      if (!RST_N)                                   tmr_q <= '0;
      else if (tmr_q == TMR_W'(REFRESH_PERIOD - 1)) tmr_q <= '0;
      else                                          tmr_q <= tmr_q + 1'b1;
    end

    assign blackout = (tmr_q < TMR_W'(REFRESH_LEN));
  end else begin : g_no_refresh
    assign blackout = 1'b0;
  end

  // A request seen in the RTY cycle is ignored, so a master holding STB
  // through a blackout sees RTY on alternate cycles.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rty_d   = 1'b0;
    accept  = 1'b0;
    load_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !rty_q) begin
          if (blackout) begin
            rty_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = BUSY;
            lat_d   = WE ? LAT_W'(WRITE_LAT - 1) : LAT_W'(READ_LAT - 1);
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
        end else if (lat_q == '0) begin
          state_d = RESP;
          load_rd = !we_q;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      lat_q   <= '0;
      rty_q   <= 1'b0;
      DAT_S   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rty_q   <= rty_d;
      if (load_rd) DAT_S <= rd_line;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q  <= WE;
      adr_q <= ADR;
      sel_q <= SEL;
      dat_q <= DAT_M;
    end
  end

  assign ACK = (state_q == RESP);
  assign RTY = rty_q;

  // Write lands on the edge closing the ACK cycle; a reset on that edge drops it.
  assign be = (ACK && we_q && RST_N) ? sel_q : '0;

  wb_line_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (CLK),
    .addr  (adr_q),
    .be    (be),
    .wdata (dat_q),
    .rdata (rd_line)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_clear)                             rd_cnt_q <= '0;
      else if (ACK && !we_q && rd_cnt_q != '1)  rd_cnt_q <= rd_cnt_q + 1'b1;
      if (wr_clear)                             wr_cnt_q <= '0;
      else if (ACK && we_q && wr_cnt_q != '1)   wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign rd_count = 16'(rd_cnt_q);
  assign wr_count = 16'(wr_cnt_q);

endmodule

// File: tb/tb_wb_line_memory_slave.sv
// Bench for wb_line_memory_slave: main instance (no refresh), refresh instance (32/4),
// and a narrow-counter instance that reaches saturation in a short run.
module tb_wb_line_memory_slave;

  localparam int NDUT = 3;
  localparam int M = 0, R = 1, S = 2;

  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [127:0] data;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    [NDUT];
  logic         cyc      [NDUT];
  logic         stb      [NDUT];
  logic         we       [NDUT];
  logic [11:0]  adr      [NDUT];
  logic [15:0]  sel      [NDUT];
  logic [127:0] dat_m    [NDUT];
  logic [127:0] dat_s    [NDUT];
  logic         ack      [NDUT];
  logic         rty      [NDUT];
  logic [15:0]  rd_count [NDUT];
  logic [15:0]  wr_count [NDUT];
  logic         rd_clear [NDUT];
  logic         wr_clear [NDUT];

  exp_t sb_q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;
  int   tmod = 0;

  localparam logic [127:0] L1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] FILL = {16{8'hAA}};

  wb_line_memory_slave #(.ADDR_BITS(12), .READ_LAT(4), .WRITE_LAT(3),
                         .REFRESH_PERIOD(0), .REFRESH_LEN(8)) u_main (
    .CLK(clk), .RST_N(rst_n[M]), .CYC(cyc[M]), .STB(stb[M]), .WE(we[M]), .ADR(adr[M]),
    .SEL(sel[M]), .DAT_M(dat_m[M]), .DAT_S(dat_s[M]), .ACK(ack[M]), .RTY(rty[M]),
    .rd_count(rd_count[M]), .wr_count(wr_count[M]), .rd_clear(rd_clear[M]), .wr_clear(wr_clear[M]));

  wb_line_memory_slave #(.ADDR_BITS(12), .READ_LAT(4), .WRITE_LAT(3),
                         .REFRESH_PERIOD(32), .REFRESH_LEN(4)) u_ref (
    .CLK(clk), .RST_N(rst_n[R]), .CYC(cyc[R]), .STB(stb[R]), .WE(we[R]), .ADR(adr[R]),
    .SEL(sel[R]), .DAT_M(dat_m[R]), .DAT_S(dat_s[R]), .ACK(ack[R]), .RTY(rty[R]),
    .rd_count(rd_count[R]), .wr_count(wr_count[R]), .rd_clear(rd_clear[R]), .wr_clear(wr_clear[R]));

  wb_line_memory_slave #(.ADDR_BITS(12), .READ_LAT(1), .WRITE_LAT(1),
                         .REFRESH_PERIOD(0), .REFRESH_LEN(8), .CNT_W(6)) u_sat (
    .CLK(clk), .RST_N(rst_n[S]), .CYC(cyc[S]), .STB(stb[S]), .WE(we[S]), .ADR(adr[S]),
    .SEL(sel[S]), .DAT_M(dat_m[S]), .DAT_S(dat_s[S]), .ACK(ack[S]), .RTY(rty[S]),
    .rd_count(rd_count[S]), .wr_count(wr_count[S]), .rd_clear(rd_clear[S]), .wr_clear(wr_clear[S]));

  // Reference refresh timer for u_ref: 0..31, held at 0 in reset.
  always @(posedge clk)
    if (!rst_n[R]) tmod <= 0;
    else           tmod <= (tmod == 31) ? 0 : tmod + 1;

  function automatic exp_t mk(input logic w, input logic [11:0] a, input logic [127:0] d, input int l);
    exp_t e;
    e.we = w; e.adr = a; e.data = d; e.lat = l;
    return e;
  endfunction

  // Drives one request from a negedge; returns negedges to ACK, the DAT_S seen in the ACK
  // cycle and whether RTY showed up. Ends one negedge after the ACK cycle.
  task automatic bus_xfer(input int d, input logic w, input logic [11:0] a, input logic [15:0] s,
                          input logic [127:0] dm, output int lat, output logic [127:0] rd,
                          output logic saw_rty);
    int n;
    logic acked;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_m[d] = dm;
    n = 0; acked = 1'b0; saw_rty = 1'b0; rd = '0;
    while (!acked && n < 60) begin
      @(negedge clk);
      n++;
      if (rty[d]) saw_rty = 1'b1;
      if (ack[d]) begin acked = 1'b1; rd = dat_s[d]; end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    lat = acked ? n - 1 : -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NDUT; i++) begin
      rst_n[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0;
      sel[i] = '0; dat_m[i] = '0; rd_clear[i] = 1'b0; wr_clear[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    ncmp++; if (ack[M] !== 1'b0) begin nfail++; $display("FAIL reset_ack: got %b want 0", ack[M]); end
    ncmp++; if (rty[M] !== 1'b0) begin nfail++; $display("FAIL reset_rty: got %b want 0", rty[M]); end
    ncmp++; if (dat_s[M] !== '0) begin nfail++; $display("FAIL reset_dat_s: got %h want 0", dat_s[M]); end
    ncmp++; if (rd_count[M] !== 16'd0 || wr_count[M] !== 16'd0) begin
      nfail++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count[M], wr_count[M]); end
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] rd; logic rt; exp_t e;
    sb_q.push_back(mk(1'b1, 12'h010, '0, 3));
    bus_xfer(M, 1'b1, 12'h010, 16'hFFFF, L1, lat, rd, rt);
    e = sb_q.pop_front(); exp_wr++;
    ncmp++; if (lat !== e.lat) begin nfail++; $display("FAIL wr_latency: got %0d want %0d", lat, e.lat); end
    sb_q.push_back(mk(1'b0, 12'h010, L1, 4));
    bus_xfer(M, 1'b0, 12'h010, 16'h0000, '0, lat, rd, rt);
    e = sb_q.pop_front(); exp_rd++;
    ncmp++; if (lat !== e.lat) begin nfail++; $display("FAIL rd_latency: got %0d want %0d", lat, e.lat); end
    ncmp++; if (rd !== e.data) begin nfail++; $display("FAIL rd_data: got %h want %h", rd, e.data); end
    ncmp++; if (rd_count[M] !== 16'(exp_rd) || wr_count[M] !== 16'(exp_wr)) begin
      nfail++; $display("FAIL wr_rd_counts: got rd=%0d wr=%0d want %0d/%0d", rd_count[M], wr_count[M], exp_rd, exp_wr); end
  endtask

  task automatic test_partial_write();
    int lat; logic [127:0] rd, dm, line; logic rt; exp_t e;
    bus_xfer(M, 1'b1, 12'h020, 16'hFFFF, FILL, lat, rd, rt); exp_wr++;
    bus_xfer(M, 1'b1, 12'h020, 16'h0003, 128'h5555555555555555555555555555BEEF, lat, rd, rt); exp_wr++;
    sb_q.push_back(mk(1'b0, 12'h020, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAABEEF, 4));
    bus_xfer(M, 1'b0, 12'h020, 16'h0000, '0, lat, rd, rt); exp_rd++;
    e = sb_q.pop_front();
    ncmp++; if (rd !== e.data) begin nfail++; $display("FAIL partial_sel3: got %h want %h", rd, e.data); end
    // Scattered lanes, expected line built byte by byte.
    line = e.data;
    dm = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) if (i == 0 || i == 7 || i == 15) line[8*i +: 8] = dm[8*i +: 8];
    bus_xfer(M, 1'b1, 12'h020, 16'h8081, dm, lat, rd, rt); exp_wr++;
    sb_q.push_back(mk(1'b0, 12'h020, line, 4));
    bus_xfer(M, 1'b0, 12'h020, 16'h0000, '0, lat, rd, rt); exp_rd++;
    e = sb_q.pop_front();
    ncmp++; if (rd !== e.data) begin nfail++; $display("FAIL partial_sel8081: got %h want %h", rd, e.data); end
    // SEL=0 write: ACKed and counted, line untouched.
    sb_q.push_back(mk(1'b1, 12'h020, '0, 3));
    bus_xfer(M, 1'b1, 12'h020, 16'h0000, ~line, lat, rd, rt); exp_wr++;
    e = sb_q.pop_front();
    ncmp++; if (lat !== e.lat) begin nfail++; $display("FAIL sel0_ack: got latency %0d want %0d", lat, e.lat); end
    bus_xfer(M, 1'b0, 12'h020, 16'h0000, '0, lat, rd, rt); exp_rd++;
    ncmp++; if (rd !== line) begin nfail++; $display("FAIL sel0_unchanged: got %h want %h", rd, line); end
    ncmp++; if (wr_count[M] !== 16'(exp_wr)) begin
      nfail++; $display("FAIL sel0_count: got %0d want %0d", wr_count[M], exp_wr); end
  endtask

  task automatic test_abort();
    int lat; logic [127:0] rd; logic rt, seen;
    logic [127:0] x1 = 128'h11112222333344445555666677778888;
    bus_xfer(M, 1'b1, 12'h030, 16'hFFFF, x1, lat, rd, rt); exp_wr++;
    cyc[M] = 1'b1; stb[M] = 1'b1; we[M] = 1'b1; adr[M] = 12'h030; sel[M] = 16'hFFFF; dat_m[M] = ~x1;
    @(negedge clk);
    stb[M] = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ack[M]) seen = 1'b1; end
    cyc[M] = 1'b0;
    ncmp++; if (seen !== 1'b0) begin nfail++; $display("FAIL abort_wr_ack: got ACK want none"); end
    ncmp++; if (wr_count[M] !== 16'(exp_wr)) begin
      nfail++; $display("FAIL abort_wr_count: got %0d want %0d", wr_count[M], exp_wr); end
    bus_xfer(M, 1'b0, 12'h030, 16'h0000, '0, lat, rd, rt); exp_rd++;
    ncmp++; if (rd !== x1) begin nfail++; $display("FAIL abort_wr_data: got %h want %h", rd, x1); end
    // Read of a different line dropped by CYC in its last BUSY cycle: DAT_S must not move.
    cyc[M] = 1'b1; stb[M] = 1'b1; we[M] = 1'b0; adr[M] = 12'h010;
    repeat (4) @(negedge clk);
    cyc[M] = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ack[M]) seen = 1'b1; end
    stb[M] = 1'b0;
    ncmp++; if (seen !== 1'b0) begin nfail++; $display("FAIL abort_rd_ack: got ACK want none"); end
    ncmp++; if (dat_s[M] !== x1) begin nfail++; $display("FAIL abort_rd_hold: got %h want %h", dat_s[M], x1); end
    ncmp++; if (rd_count[M] !== 16'(exp_rd)) begin
      nfail++; $display("FAIL abort_rd_count: got %0d want %0d", rd_count[M], exp_rd); end
  endtask

  task automatic test_back_to_back();
    int lat, n, last, acks; logic [127:0] rd; logic rt; exp_t e;
    logic [127:0] b1 = 128'hB1B1B1B1_00000000_CAFEF00D_12345678;
    bus_xfer(M, 1'b1, 12'h050, 16'hFFFF, b1, lat, rd, rt); exp_wr++;
    for (int i = 0; i < 3; i++) sb_q.push_back(mk(1'b0, 12'h050, b1, (i == 0) ? 4 : 5));
    cyc[M] = 1'b1; stb[M] = 1'b1; we[M] = 1'b0; adr[M] = 12'h050;
    n = 0; last = 0; acks = 0;
    while (acks < 3 && n < 60) begin
      @(negedge clk); n++;
      if (ack[M]) begin
        e = sb_q.pop_front(); acks++;
        // First gap counts edges from accept; later gaps include the cycle after ACK.
        ncmp++; if (n - last - 1 !== e.lat) begin
          nfail++; $display("FAIL b2b_gap%0d: got %0d want %0d", acks, n - last - 1, e.lat); end
        ncmp++; if (dat_s[M] !== e.data) begin
          nfail++; $display("FAIL b2b_data%0d: got %h want %h", acks, dat_s[M], e.data); end
        last = n;
        if (acks == 3) begin cyc[M] = 1'b0; stb[M] = 1'b0; end
      end
    end
    cyc[M] = 1'b0; stb[M] = 1'b0;
    ncmp++; if (acks !== 3) begin nfail++; $display("FAIL b2b_timeout: got %0d ACKs want 3", acks); sb_q.delete(); end
    @(negedge clk);
    exp_rd += acks;
    // A write ACK leaves the last read data on DAT_S.
    bus_xfer(M, 1'b1, 12'h050, 16'hFFFF, ~b1, lat, rd, rt); exp_wr++;
    ncmp++; if (rd !== b1) begin nfail++; $display("FAIL dat_s_hold: got %h want %h", rd, b1); end
    ncmp++; if (rd_count[M] !== 16'(exp_rd)) begin
      nfail++; $display("FAIL b2b_count: got %0d want %0d", rd_count[M], exp_rd); end
  endtask

  task automatic test_clear();
    int n; logic seen; logic [127:0] got;
    cyc[M] = 1'b1; stb[M] = 1'b1; we[M] = 1'b0; adr[M] = 12'h050;
    n = 0; seen = 1'b0; got = '0;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      if (ack[M]) begin seen = 1'b1; got = dat_s[M]; end
    end
    cyc[M] = 1'b0; stb[M] = 1'b0;
    rd_clear[M] = 1'b1; wr_clear[M] = 1'b1;
    @(negedge clk);
    rd_clear[M] = 1'b0; wr_clear[M] = 1'b0;
    ncmp++; if (!seen || got !== ~128'hB1B1B1B1_00000000_CAFEF00D_12345678) begin
      nfail++; $display("FAIL clear_read: got ack=%b data=%h", seen, got); end
    ncmp++; if (rd_count[M] !== 16'd0 || wr_count[M] !== 16'd0) begin
      nfail++; $display("FAIL clear_counts: got rd=%0d wr=%0d want 0/0", rd_count[M], wr_count[M]); end
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_refresh();
    int k, lat; logic [127:0] rd; logic rt, seen; exp_t e;
    logic [127:0] rl = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    k = 0;
    while (tmod != 1 && k < 64) begin @(negedge clk); k++; end
    cyc[R] = 1'b1; stb[R] = 1'b1; we[R] = 1'b0; adr[R] = 12'h005;
    @(negedge clk);
    ncmp++; if (rty[R] !== 1'b1 || ack[R] !== 1'b0) begin
      nfail++; $display("FAIL rty_pulse: got rty=%b ack=%b want 1/0", rty[R], ack[R]); end
    @(negedge clk);
    ncmp++; if (rty[R] !== 1'b0) begin nfail++; $display("FAIL rty_alternate: got %b want 0", rty[R]); end
    @(negedge clk);
    ncmp++; if (rty[R] !== 1'b1) begin nfail++; $display("FAIL rty_again: got %b want 1", rty[R]); end
    cyc[R] = 1'b0; stb[R] = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (ack[R] || rty[R]) seen = 1'b1; end
    ncmp++; if (seen !== 1'b0) begin nfail++; $display("FAIL rty_quiet: got ACK/RTY want none"); end
    // Timer is now past the blackout: retry completes with normal latency.
    sb_q.push_back(mk(1'b0, 12'h005, '0, 4));
    bus_xfer(R, 1'b0, 12'h005, 16'h0000, '0, lat, rd, rt);
    e = sb_q.pop_front();
    ncmp++; if (lat !== e.lat || rt !== 1'b0) begin
      nfail++; $display("FAIL retry_read: got latency %0d rty=%b want %0d/0", lat, rt, e.lat); end
    bus_xfer(R, 1'b1, 12'h005, 16'hFFFF, rl, lat, rd, rt);
    k = 0;
    while (tmod != 31 && k < 64) begin @(negedge clk); k++; end
    sb_q.push_back(mk(1'b0, 12'h005, rl, 4));
    bus_xfer(R, 1'b0, 12'h005, 16'h0000, '0, lat, rd, rt);
    e = sb_q.pop_front();
    ncmp++; if (lat !== e.lat || rt !== 1'b0) begin
      nfail++; $display("FAIL busy_through_blackout: got latency %0d rty=%b want %0d/0", lat, rt, e.lat); end
    ncmp++; if (rd !== e.data) begin nfail++; $display("FAIL blackout_data: got %h want %h", rd, e.data); end
  endtask

  task automatic test_counters();
    int n, acks, want;
    cyc[S] = 1'b1; stb[S] = 1'b1; we[S] = 1'b0; adr[S] = 12'h000;
    n = 0; acks = 0;
    while (acks < 70 && n < 400) begin
      @(negedge clk); n++;
      if (ack[S]) begin
        want = (acks > 63) ? 63 : acks;
        ncmp++; if (rd_count[S] !== 16'(want)) begin
          nfail++; $display("FAIL sat_count@%0d: got %0d want %0d", acks, rd_count[S], want); end
        acks++;
      end
    end
    cyc[S] = 1'b0; stb[S] = 1'b0;
    @(negedge clk);
    ncmp++; if (acks !== 70 || rd_count[S] !== 16'd63) begin
      nfail++; $display("FAIL sat_final: got %0d acks count %0d want 70/63", acks, rd_count[S]); end
    ncmp++; if (wr_count[S] !== 16'd0) begin nfail++; $display("FAIL sat_wr: got %0d want 0", wr_count[S]); end
    rd_clear[S] = 1'b1;
    @(negedge clk);
    rd_clear[S] = 1'b0;
    ncmp++; if (rd_count[S] !== 16'd0) begin nfail++; $display("FAIL sat_clear: got %0d want 0", rd_count[S]); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [127:0] rd; logic rt, seen; exp_t e;
    logic [127:0] d1 = 128'hD1D1D1D1D1D1D1D1_0000111122223333;
    bus_xfer(M, 1'b1, 12'h040, 16'hFFFF, d1, lat, rd, rt); exp_wr++;
    cyc[M] = 1'b1; stb[M] = 1'b1; we[M] = 1'b1; adr[M] = 12'h040; sel[M] = 16'hFFFF; dat_m[M] = ~d1;
    repeat (2) @(negedge clk);
    rst_n[M] = 1'b0; cyc[M] = 1'b0; stb[M] = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (ack[M] || rty[M]) seen = 1'b1; end
    rst_n[M] = 1'b1;
    repeat (4) begin @(negedge clk); if (ack[M] || rty[M]) seen = 1'b1; end
    ncmp++; if (seen !== 1'b0) begin nfail++; $display("FAIL midrst_pulse: got ACK/RTY want none"); end
    ncmp++; if (rd_count[M] !== 16'd0 || wr_count[M] !== 16'd0 || dat_s[M] !== '0) begin
      nfail++; $display("FAIL midrst_state: got rd=%0d wr=%0d dat_s=%h want 0", rd_count[M], wr_count[M], dat_s[M]); end
    exp_rd = 0; exp_wr = 0;
    sb_q.push_back(mk(1'b0, 12'h040, d1, 4));
    bus_xfer(M, 1'b0, 12'h040, 16'h0000, '0, lat, rd, rt); exp_rd++;
    e = sb_q.pop_front();
    ncmp++; if (lat !== e.lat || rd !== e.data) begin
      nfail++; $display("FAIL midrst_read: got latency %0d data %h want %0d/%h", lat, rd, e.lat, e.data); end
    ncmp++; if (rd_count[M] !== 16'(exp_rd)) begin
      nfail++; $display("FAIL midrst_count: got %0d want %0d", rd_count[M], exp_rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_abort();
    test_back_to_back();
    test_clear();
    test_refresh();
    test_counters();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", ncmp, nfail);
    $fatal(1, "watchdog");
  end

endmodule
